if_stage: RTL and testbench

//   Instruction-fetch stage of the 5-stage MIPS pipeline; sits directly upstream of ID.

---
 rtl/if_stage_if.sv | 24 ++
 rtl/if_stage.sv | 162 ++++++++++++++++
 tb/tb_if_stage.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Bus bundle between the IF stage and its neighbours (ID, EX, hazard unit, imem).
// master = the IF stage itself; slave = everything around it.
interface if_stage_if;
    logic        stall;
    logic [1:0]  PCSrc;
    logic [31:0] jr_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] IR;
    logic [31:0] PC_plus4_out;
    logic        valid_out;

    modport master (
        input  stall, PCSrc, jr_target, branch_taken, branch_target, imem_rdata,
        output imem_addr, IR, PC_plus4_out, valid_out
    );

    modport slave (
        output stall, PCSrc, jr_target, branch_taken, branch_target, imem_rdata,
        input  imem_addr, IR, PC_plus4_out, valid_out
    );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select and the IF/ID register.
// Optional IF_PERF_CNT_EN adds fetch_count / bubble_count performance counters.
//
// state | meaning
// BOOT  | first cycle out of reset; PC held, IF/ID forced to a bubble
// RUN   | normal fetch with branch / stall / jump / jr redirect priority
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    if_stage_if.master  bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] ir_q;
    logic [31:0] ir_d;
    logic [31:0] pc4_q;
    logic [31:0] pc4_d;
    logic        valid_q;
    logic        valid_d;

    logic [31:0] seq_pc;
    logic [31:0] jump_pc;
    logic        load_valid;
    logic        count_bubble;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
        end
    end

    // ---------------------------------------------------------------- datapath / outputs
    assign seq_pc  = pc_q + 32'd4;
    assign jump_pc = {pc4_q[31:28], ir_q[25:0], 2'b00};

    always_comb begin
        pc_d         = pc_q;
        ir_d         = ir_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        load_valid   = 1'b0;
        count_bubble = 1'b0;

        if (state_q == ST_BOOT) begin
            ir_d    = NOP_WORD;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end else if (bus.branch_taken) begin
            // EX redirect wins even over a stall: the stalled fetch is on the wrong path
            pc_d         = bus.branch_target;
            ir_d         = NOP_WORD;
            pc4_d        = 32'd0;
            valid_d      = 1'b0;
            count_bubble = 1'b1;
        end else if (bus.stall) begin
            count_bubble = 1'b1;
        end else if (valid_q && (bus.PCSrc == 2'b01)) begin
            pc_d         = jump_pc;
            ir_d         = NOP_WORD;
            pc4_d        = 32'd0;
            valid_d      = 1'b0;
            count_bubble = 1'b1;
        end else if (valid_q && (bus.PCSrc == 2'b10)) begin
            pc_d         = bus.jr_target;
            ir_d         = NOP_WORD;
            pc4_d        = 32'd0;
            valid_d      = 1'b0;
            count_bubble = 1'b1;
        end else begin
            pc_d       = seq_pc;
            ir_d       = bus.imem_rdata;
            pc4_d      = seq_pc;
            valid_d    = 1'b1;
            load_valid = 1'b1;
        end

        // misaligned redirect targets are truncated to a word boundary
        pc_d[1:0] = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            ir_q    <= NOP_WORD;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign bus.imem_addr    = pc_q;
    assign bus.IR           = ir_q;
    assign bus.PC_plus4_out = pc4_q;
    assign bus.valid_out    = valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] fetch_cnt_d;
    logic [31:0] bubble_cnt_q;
    logic [31:0] bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (load_valid) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (count_bubble) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = load_valid ^ count_bubble;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed hazard scenarios followed by random traffic,
// all checked against a cycle-level reference model of the fetch rules.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] J_WORD   = 32'h0810_0010;

    logic clk = 1'b0;
    logic reset;
    if_stage_if bus ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    if_stage dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_count  (fetch_count),
        .bubble_count (bubble_count)
`endif
    );

    always #5 clk = ~clk;

    // instruction memory: a fixed scramble of the address, with a j at 0x00400004
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0004) return J_WORD;
        return (a * 32'h0100_0193) ^ 32'h5BD1_E995;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_boot;
    logic [31:0] m_fc;
    logic [31:0] m_bc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_bubble();
        m_ir    = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    // reference: one rising edge of the fetch stage, rules in priority order
    task automatic model_step();
        logic [31:0] next_pc;
        next_pc = m_pc;
        if (!reset) begin
            next_pc = RESET_PC;
            m_bubble();
            m_boot = 1'b1;
            m_fc   = 0;
            m_bc   = 0;
        end else if (m_boot) begin
            m_bubble();
            m_boot = 1'b0;
        end else if (bus.branch_taken) begin
            next_pc = bus.branch_target & ~32'd3;
            m_bubble();
            m_bc++;
        end else if (bus.stall) begin
            m_bc++;
        end else if (m_valid && bus.PCSrc == 2'b01) begin
            next_pc = {m_pc4[31:28], m_ir[25:0], 2'b00};
            m_bubble();
            m_bc++;
        end else if (m_valid && bus.PCSrc == 2'b10) begin
            next_pc = bus.jr_target & ~32'd3;
            m_bubble();
            m_bc++;
        end else begin
            m_ir    = mem_word(m_pc);
            next_pc = m_pc + 32'd4;
            m_pc4   = next_pc;
            m_valid = 1'b1;
            m_fc++;
        end
        m_pc = next_pc;
    endtask

    task automatic check_all();
        check("addr",  bus.imem_addr,           m_pc);
        check("ir",    bus.IR,                  m_ir);
        check("pc4",   bus.PC_plus4_out,        m_pc4);
        check("valid", {31'd0, bus.valid_out},  {31'd0, m_valid});
`ifdef IF_PERF_CNT_EN
        check("fetch_cnt",  fetch_count,  m_fc);
        check("bubble_cnt", bubble_count, m_bc);
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic st, input logic [1:0] pcs, input logic [31:0] jr,
                         input logic bt, input logic [31:0] btgt);
        bus.stall         = st;
        bus.PCSrc         = pcs;
        bus.jr_target     = jr;
        bus.branch_taken  = bt;
        bus.branch_target = btgt;
    endtask

    initial begin
        m_pc = 0; m_ir = 0; m_pc4 = 0; m_valid = 0; m_boot = 1; m_fc = 0; m_bc = 0;

        // reset held 2 cycles with hazards asserted: must be ignored
        reset = 1'b0;
        drive(1'b1, 2'b01, 32'h1234_5678, 1'b1, 32'h0040_0200);
        cyc(); cyc();
        check("rst_addr",  bus.imem_addr,          RESET_PC);
        check("rst_ir",    bus.IR,                 32'h0);
        check("rst_pc4",   bus.PC_plus4_out,       32'h0);
        check("rst_valid", {31'd0, bus.valid_out}, 32'd0);

        // BOOT ignores stall / jumps / branches
        reset = 1'b1;
        cyc();
        check("boot_addr",  bus.imem_addr,          RESET_PC);
        check("boot_valid", {31'd0, bus.valid_out}, 32'd0);

        drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
        cyc();
        check("first_ir",   bus.IR,           mem_word(RESET_PC));
        check("first_pc4",  bus.PC_plus4_out, 32'h0040_0004);
        check("seq_addr1",  bus.imem_addr,    32'h0040_0004);
        cyc();
        check("seq_addr2",  bus.imem_addr,    32'h0040_0008);
        cyc();
        check("seq_addr3",  bus.imem_addr,    32'h0040_000C);
        check("seq_valid",  {31'd0, bus.valid_out}, 32'd1);

        // j: re-run from reset so IR holds the j with PC+4 = 0x00400008
        reset = 1'b0; cyc(); cyc();
        reset = 1'b1; cyc(); cyc(); cyc();
        check("j_ir",  bus.IR,           J_WORD);
        check("j_pc4", bus.PC_plus4_out, 32'h0040_0008);
        drive(1'b0, 2'b01, 32'h0, 1'b0, 32'h0);
        cyc();
        check("j_addr",   bus.imem_addr,          32'h0040_0040);
        check("j_bubble", {31'd0, bus.valid_out}, 32'd0);
        drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
        cyc();
        check("j_target_ir", bus.IR, mem_word(32'h0040_0040));

        // jr with misaligned target
        drive(1'b0, 2'b10, 32'h0040_0123, 1'b0, 32'h0);
        cyc();
        check("jr_addr",   bus.imem_addr,          32'h0040_0120);
        check("jr_bubble", {31'd0, bus.valid_out}, 32'd0);
        drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
        cyc();

        // two-cycle stall with a jump presented: everything holds
        drive(1'b1, 2'b01, 32'h0, 1'b0, 32'h0);
        cyc(); cyc();
        check("stall_addr", bus.imem_addr,    32'h0040_0124);
        check("stall_ir",   bus.IR,           mem_word(32'h0040_0120));
        check("stall_pc4",  bus.PC_plus4_out, 32'h0040_0124);

        // branch overrides stall
        drive(1'b1, 2'b00, 32'h0, 1'b1, 32'h0040_0200);
        cyc();
        check("br_addr",  bus.imem_addr,          32'h0040_0200);
        check("br_valid", {31'd0, bus.valid_out}, 32'd0);
        drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
        cyc();

        // wrap at top of address space, misaligned branch target
        drive(1'b0, 2'b00, 32'h0, 1'b1, 32'hFFFF_FFFE);
        cyc();
        check("wrap_br_addr", bus.imem_addr, 32'hFFFF_FFFC);
        drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
        cyc();
        check("wrap_addr", bus.imem_addr,    32'h0);
        check("wrap_pc4",  bus.PC_plus4_out, 32'h0);
        check("wrap_ir",   bus.IR,           mem_word(32'hFFFF_FFFC));

        // reset mid-run beats stall and branch
        drive(1'b1, 2'b01, 32'h0, 1'b1, 32'h0040_0300);
        reset = 1'b0;
        cyc();
        check("midrst_addr",  bus.imem_addr,          RESET_PC);
        check("midrst_valid", {31'd0, bus.valid_out}, 32'd0);

        // 10 fetches then 3 stalled cycles
        reset = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
        cyc();
        repeat (10) cyc();
        drive(1'b1, 2'b00, 32'h0, 1'b0, 32'h0);
        repeat (3) cyc();
`ifdef IF_PERF_CNT_EN
        check("perf_fetch",  fetch_count,  32'd10);
        check("perf_bubble", bubble_count, 32'd3);
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) != 0);
            drive(($urandom_range(0, 3) == 0),
                  2'($urandom_range(0, 3)),
                  $urandom,
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
